// File: rtl/vrf_pkg.sv
// Shared types and helpers for the VRF writeback arbiter: state encoding,
// requester indices and width helpers.
package vrf_pkg;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_GRANT = 2'd1,
    WB_BURST = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_e;

  // Width helpers never return 0, so a single-register or single-lane build
  // still gets a legal one-bit field.
  function automatic int addr_bits(input int reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

  function automatic int elem_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vrf_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, LSU), the read sequencer
// busy flag and the latch VRF write port.
interface vrf_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4
);
  import vrf_pkg::*;

  localparam int ADDR_B = addr_bits(REG_NUM);
  localparam int ELEM_B = elem_bits(LANES);

  logic [1:0]                 req_i;
  logic [1:0][ADDR_B-1:0]     addr_i;
  logic [1:0]                 valid_i;
  logic [1:0][DATA_WIDTH-1:0] data_i;
  logic [1:0]                 gnt_o;
  logic [1:0]                 ready_o;
  logic [1:0]                 done_o;
  logic                       rd_busy_i;
  logic                       vrf_wr_req_o;
  logic                       vrf_wr_en_o;
  logic                       vrf_wr_ready_o;
  logic [ADDR_B-1:0]          vrf_wr_addr_o;
  logic [ELEM_B-1:0]          vrf_wr_elem_cnt_o;
  logic [DATA_WIDTH-1:0]      vrf_wdata_o;

  modport master (
    output req_i, addr_i, valid_i, data_i, rd_busy_i,
    input  gnt_o, ready_o, done_o,
    input  vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o,
    input  vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o
  );

  modport slave (
    input  req_i, addr_i, valid_i, data_i, rd_busy_i,
    output gnt_o, ready_o, done_o,
    output vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o,
    output vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o
  );

endinterface

// File: rtl/vrf_wb_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the side named by ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Shares the single latch-VRF write port between the ALU and LSU writeback
// paths, one whole vector per grant, round-robin between the two.
module vrf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4
) (
  input logic               clk_i,
  input logic               resetn_i,
  vrf_wb_arbiter_if.slave   bus
);
  import vrf_pkg::*;

  localparam int ADDR_B = addr_bits(REG_NUM);
  localparam int ELEM_B = elem_bits(LANES);
  localparam logic [ELEM_B-1:0] LAST_ELEM = ELEM_B'(LANES - 1);

  wb_state_e         state;
  logic              win;
  logic              ptr;
  logic [ADDR_B-1:0] addr_q;
  logic [ELEM_B-1:0] elem_cnt;
  logic [1:0]        pick;
  logic              beat;
  logic              last_beat;

  rr_arb2 u_rr_arb2 (
    .req (bus.req_i),
    .ptr (ptr),
    .gnt (pick)
  );

  assign beat      = (state == WB_BURST) && bus.valid_i[win];
  assign last_beat = beat && (elem_cnt == LAST_ELEM);

  // A new grant is only taken from IDLE and only while the read sequencer is
  // quiet; once granted, the vector runs to completion regardless of req/busy.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state    <= WB_IDLE;
      win      <= 1'b0;
      ptr      <= 1'b0;
      addr_q   <= '0;
      elem_cnt <= '0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (|bus.req_i && !bus.rd_busy_i) begin
            win    <= pick[1];
            addr_q <= bus.addr_i[pick[1]];
            state  <= WB_GRANT;
          end
        end
        WB_GRANT: state <= WB_BURST;
        WB_BURST: begin
          if (beat) begin
            if (last_beat) begin
              elem_cnt <= '0;
              state    <= WB_DONE;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end
        WB_DONE: begin
          ptr   <= ~win;
          state <= WB_IDLE;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // Requester-facing handshakes are pure state decodes steered to the winner.
  always_comb begin
    bus.gnt_o   = '0;
    bus.ready_o = '0;
    bus.done_o  = '0;
    if (state == WB_GRANT || state == WB_BURST) bus.gnt_o[win] = 1'b1;
    if (state == WB_BURST) bus.ready_o[win] = 1'b1;
    if (state == WB_DONE) bus.done_o[win] = 1'b1;
  end

  assign bus.vrf_wr_req_o      = (state == WB_GRANT);
  assign bus.vrf_wr_en_o       = beat;
  assign bus.vrf_wr_ready_o    = last_beat;
  assign bus.vrf_wr_addr_o     = addr_q;
  assign bus.vrf_wr_elem_cnt_o = elem_cnt;
  assign bus.vrf_wdata_o       = (state == WB_BURST) ? bus.data_i[win] : '0;

endmodule
